fpaddsub_seq: RTL and testbench
===============================

# fpaddsub_seq

Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor, the successor to our single-precision sequential adder. Exponent and mantissa widths are generic, so one block covers half, single and double precision. It adds a subtract mode, round-to-nearest-even, full special-value handling, a busy/done handshake and exception flags. It sits behind the datapath's operand registers and is started one operation at a time.

## Interface
- EXP_W, default 8: exponent field width.
- MAN_W, default 23: stored fraction width; word width W = 1+EXP_W+MAN_W.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  operation request; sampled only when busy=0.
- sub  in  1  0: a+b, 1: a−b; sampled with start.
- a, b  in  W  operands; sampled with start.
- sum  out  W  result; held until the next done.
- done  out  1  one-cycle pulse, sum/flags valid.
- busy  out  1  high from the cycle after start is accepted until done.
- flags  out  4  {inv, ovf, unf, inx}; valid with done, held with sum.

## Operation
- Reset values: sum=0, flags=0, done=0, busy=0, state=IDLE.
- States: IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE, with done and busy updated on the exit edge.
- UNPACK:
  - Effective b sign = b[W−1] XOR sub.
  - Exponent 0 is treated as zero; subnormal inputs are flushed.
  - Operands are swapped so |A| ≥ |B|.
  - Hidden 1 is restored.
- Specials are resolved in UNPACK and exit directly:
  - Any NaN, or inf − inf, gives canonical qNaN {0, all-ones, 1, 0…}. inv=1 only for inf − inf and signalling NaN.
  - inf ± finite gives that inf.
  - zero ± zero gives sign = AND of the effective signs.
  - zero ± x gives x.
- ALIGN:
  - B is shifted right by the exponent difference in one cycle, into a (MAN_W+4)-bit field: hidden, fraction, guard, round, sticky.
  - Shifted-out bits are ORed into sticky.
  - A difference above MAN_W+3 leaves only sticky.
- ADD:
  - Same effective signs: magnitude add with a carry bit.
  - Different signs: A − B.
  - Result sign = sign of A.
  - An exactly zero difference exits with +0.
- NORM:
  - First cycle: on carry, shift right 1 (keeping sticky) and add 1 to the exponent.
  - Each further cycle: shift left 1 and subtract 1 from the exponent, until the hidden bit is 1.
  - If the exponent would reach 0: flush to signed zero, set unf=1 and inx=1, and exit.
- ROUND:
  - RNE: increment when G & (R | S | lsb).
  - inx = G | R | S.
  - A mantissa overflow renormalises by a right shift and exponent+1.
  - If the exponent reaches all-ones: ±inf, ovf=1, inx=1.

## Timing
- Start is taken when start=1 and busy=0 (cycle 0). Start while busy=1 is ignored, and the operands are not re-sampled.
- Normal path: done at cycle 6+k, where k is the number of NORM left shifts (0…MAN_W+2).
- Special-value exit: done at cycle 2.
- Zero-difference exit: done at cycle 4.
- busy=1 during cycles 1 through done−1; busy=0 in the done cycle.
- A new start may be asserted in the done cycle and is accepted.
- Asynchronous reset mid-operation: outputs return to reset values immediately. No done is produced for the aborted operation.

## Test plan
- 0x3F800000 + 0x3F800000, sub=0 → sum=0x40000000, flags=0, done at cycle 6, busy high for cycles 1–5.
- 0x3F800000 − 0x3F7FFFFF (sub=1) → sum=0x33800000, flags=0, done at cycle 6+k with k matching the normalisation shifts.
- RNE ties:
  - 0x3F800000 + 0x33800000 → 0x3F800000, inx=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, inx=1.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, inv=1, done at cycle 2.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, ovf=1, inx=1.
  - 0x80000000 + 0x80000000 → 0x80000000.
- Cancellation: 0x40490FDB − 0x40490FDB → 0x00000000, done at cycle 4. Repeat with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
- Control:
  - Start pulsed again at cycle 3 with different operands → ignored; first result unchanged.
  - reset=0 at cycle 3 → sum=0, busy=0, no done.
  - A start in the done cycle → accepted.

Source files
------------

// File: rtl/fpaddsub_seq_if.sv
// Request/result bundle for fpaddsub_seq.
// The master drives operands and start; the slave returns sum, flags and the busy/done handshake.
interface fpaddsub_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         done;
  logic         busy;
  logic [3:0]   flags;

  modport master (output start, sub, a, b, input sum, done, busy, flags);
  modport slave  (input start, sub, a, b, output sum, done, busy, flags);
endinterface

// File: rtl/fpaddsub_seq.sv
// Multi-cycle floating-point add/subtract with generic exponent/fraction widths.
// Flow: unpack, align, add, normalise, then round to nearest even. Flags are {inv, ovf, unf, inx}.
module fpaddsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic          clk,
  input  logic          reset,
  fpaddsub_seq_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int F = MAN_W + 4;
  localparam int E = EXP_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;
  localparam logic [EXP_W-1:0] MAX_SHIFT = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d;
  logic             sign_q, sign_d, eff_sub_q, eff_sub_d, first_q, first_d;
  logic [E-1:0]     exp_q, exp_d;
  logic [EXP_W-1:0] diff_q, diff_d;
  logic [F-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [F:0]       m_q, m_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d, busy_q, busy_d;

  // Operand decode, using the effective sign of b.
  logic             sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign sa     = a_q[W-1];
  assign sb     = b_q[W-1] ^ sub_q;
  assign ea     = a_q[W-2:MAN_W];
  assign eb     = b_q[W-2:MAN_W];
  assign fa     = a_q[MAN_W-1:0];
  assign fb     = b_q[MAN_W-1:0];
  assign a_nan  = (ea == EXP_ONES) && (fa != '0);
  assign b_nan  = (eb == EXP_ONES) && (fb != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_snan = b_nan && !fb[MAN_W-1];
  assign a_inf  = (ea == EXP_ONES) && (fa == '0);
  assign b_inf  = (eb == EXP_ONES) && (fb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign swap   = {eb, fb} > {ea, fa};

  logic         special;
  logic [W-1:0] spec_sum;
  logic [3:0]   spec_flags;
  always_comb begin
    special    = 1'b1;
    spec_sum   = QNAN;
    spec_flags = 4'b0000;
    if (a_nan || b_nan)                   spec_flags = {a_snan | b_snan, 3'b000};
    else if (a_inf && b_inf && (sa != sb)) spec_flags = 4'b1000;
    else if (a_inf)                       spec_sum = {sa, a_q[W-2:0]};
    else if (b_inf)                       spec_sum = {sb, b_q[W-2:0]};
    else if (a_zero && b_zero)            spec_sum = {sa & sb, {(W-1){1'b0}}};
    else if (a_zero)                      spec_sum = {sb, b_q[W-2:0]};
    else if (b_zero)                      spec_sum = {sa, a_q[W-2:0]};
    else                                  special = 1'b0;
  end

  // Alignment shifter; everything shifted out collapses into the sticky bit.
  logic [F-1:0] b_shift, aligned;
  logic         b_sticky;
  always_comb begin
    if (diff_q > MAX_SHIFT) begin
      b_shift  = '0;
      b_sticky = |mb_q;
    end else begin
      b_shift  = mb_q >> diff_q;
      b_sticky = |(mb_q & ~({F{1'b1}} << diff_q));
    end
  end
  assign aligned = {b_shift[F-1:1], b_shift[0] | b_sticky};

  logic [MAN_W:0]   keep;
  logic             g_bit, r_bit, s_bit, inc;
  logic [MAN_W+1:0] rnd;
  logic [E-1:0]     exp_r;
  logic [MAN_W-1:0] frac_r;
  assign keep   = m_q[F-1:3];
  assign g_bit  = m_q[2];
  assign r_bit  = m_q[1];
  assign s_bit  = m_q[0];
  assign inc    = g_bit & (r_bit | s_bit | keep[0]);
  assign rnd    = {1'b0, keep} + {{(MAN_W+1){1'b0}}, inc};
  assign exp_r  = exp_q + {{(E-1){1'b0}}, rnd[MAN_W+1]};
  assign frac_r = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    sign_d    = sign_q;
    eff_sub_d = eff_sub_q;
    first_d   = first_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    m_d       = m_q;
    sum_d     = sum_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        if (special) begin
          sum_d   = spec_sum;
          flags_d = spec_flags;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          eff_sub_d = sa ^ sb;
          state_d   = S_ALIGN;
          if (swap) begin
            sign_d = sb;
            exp_d  = {1'b0, eb};
            diff_d = eb - ea;
            ma_d   = {1'b1, fb, 3'b000};
            mb_d   = {1'b1, fa, 3'b000};
          end else begin
            sign_d = sa;
            exp_d  = {1'b0, ea};
            diff_d = ea - eb;
            ma_d   = {1'b1, fa, 3'b000};
            mb_d   = {1'b1, fb, 3'b000};
          end
        end
      end
      S_ALIGN: begin
        mb_d    = aligned;
        state_d = S_ADD;
      end
      S_ADD: begin
        first_d = 1'b1;
        state_d = S_NORM;
        if (eff_sub_q) begin
          m_d = {1'b0, ma_q} - {1'b0, mb_q};
          if (m_d == '0) begin
            sum_d   = '0;
            flags_d = 4'b0000;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          m_d = {1'b0, ma_q} + {1'b0, mb_q};
        end
      end
      S_NORM: begin
        first_d = 1'b0;
        if (first_q) begin
          if (m_q[F]) begin
            m_d     = {1'b0, m_q[F:2], m_q[1] | m_q[0]};
            exp_d   = exp_q + E'(1);
            state_d = S_ROUND;
          end else if (m_q[F-1]) begin
            state_d = S_ROUND;
          end
        end else if (exp_q == E'(1)) begin
          // One more left shift would need exponent 0: flush instead.
          sum_d   = {sign_q, {(W-1){1'b0}}};
          flags_d = 4'b0011;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          m_d   = m_q << 1;
          exp_d = exp_q - E'(1);
          if (m_q[F-2]) state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (exp_r >= {1'b0, EXP_ONES}) begin
          sum_d   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          flags_d = 4'b0101;
        end else begin
          sum_d   = {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_d = {3'b000, g_bit | r_bit | s_bit};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      first_q   <= 1'b0;
      exp_q     <= '0;
      diff_q    <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      m_q       <= '0;
      sum_q     <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sub_q     <= sub_d;
      sign_q    <= sign_d;
      eff_sub_q <= eff_sub_d;
      first_q   <= first_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      m_q       <= m_d;
      sum_q     <= sum_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.flags = flags_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_fpaddsub_seq.sv
// Directed bench for fpaddsub_seq: single-precision instance plus a half-precision instance.
// Expected sums, flags and done latencies are hand-computed.
module tb_fpaddsub_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  fpaddsub_seq_if #(.EXP_W(8), .MAN_W(23)) sbus ();
  fpaddsub_seq_if #(.EXP_W(5), .MAN_W(10)) hbus ();

  fpaddsub_seq #(.EXP_W(8), .MAN_W(23)) u_sp (.clk(clk), .reset(reset), .bus(sbus));
  fpaddsub_seq #(.EXP_W(5), .MAN_W(10)) u_hp (.clk(clk), .reset(reset), .bus(hbus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  // Called just after a rising edge; start is seen by the next edge (end of cycle 0).
  task automatic start_op(input bit half, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (half) begin
      hbus.a = a[15:0]; hbus.b = b[15:0]; hbus.sub = s; hbus.start = 1'b1;
    end else begin
      sbus.a = a; sbus.b = b; sbus.sub = s; sbus.start = 1'b1;
    end
    @(posedge clk); #1;
    sbus.start = 1'b0;
    hbus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit half, input int c0, output int cyc);
    int busy_low;
    busy_low = 0;
    cyc = c0;
    while (!(half ? hbus.done : sbus.done) && cyc < 80) begin
      if (!(half ? hbus.busy : sbus.busy)) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/busy_during"}, 64'(busy_low), 64'd0);
  endtask

  task automatic run(input string tag, input bit half, input logic [31:0] a, input logic [31:0] b,
                     input logic s, input logic [31:0] want_sum, input logic [3:0] want_flags,
                     input int want_lat);
    int cyc;
    start_op(half, a, b, s);
    wait_done(tag, half, 1, cyc);
    check({tag, "/latency"}, 64'(cyc), 64'(want_lat));
    check({tag, "/busy_at_done"}, 64'(half ? hbus.busy : sbus.busy), 64'd0);
    check({tag, "/sum"}, half ? 64'(hbus.sum) : 64'(sbus.sum), 64'(want_sum));
    check({tag, "/flags"}, 64'(half ? hbus.flags : sbus.flags), 64'(want_flags));
    $display("op %-10s a=%08h b=%08h sub=%0d -> sum=%08h flags=%04b cycle=%0d", tag, a, b, s,
             half ? 32'(hbus.sum) : sbus.sum, half ? hbus.flags : sbus.flags, cyc);
  endtask

  initial begin
    int cyc;
    int dones;
    sbus.start = 1'b0; sbus.sub = 1'b0; sbus.a = '0; sbus.b = '0;
    hbus.start = 1'b0; hbus.sub = 1'b0; hbus.a = '0; hbus.b = '0;
    #12;
    check("rst/sum", 64'(sbus.sum), 64'd0);
    check("rst/flags", 64'(sbus.flags), 64'd0);
    check("rst/done", 64'(sbus.done), 64'd0);
    check("rst/busy", 64'(sbus.busy), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run("one+one",  0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 6);
    run("cancel24", 0, 32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000, 30);
    run("tie_even", 0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6);
    run("tie_odd",  0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 6);
    run("inf-inf",  0, 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    run("ovf",      0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6);
    run("negzero",  0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2);
    run("pi-pi",    0, 32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 4'b0000, 4);
    run("qnan",     0, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2);
    run("snan",     0, 32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 2);
    run("zero-x",   0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 2);
    run("inf-x",    0, 32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000, 2);
    run("swap_sub", 0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 7);
    run("unf",      0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 6);
    run("half",     1, 32'h00003C00, 32'h00003C00, 1'b0, 32'h00004000, 4'b0000, 6);

    // Second start at cycle 3 must be ignored.
    start_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sbus.a = 32'h40400000; sbus.b = 32'h40400000; sbus.start = 1'b1;
    @(posedge clk); #1;
    sbus.start = 1'b0;
    wait_done("busy_start", 0, 4, cyc);
    check("busy_start/latency", 64'(cyc), 64'd6);
    check("busy_start/sum", 64'(sbus.sum), 64'h40000000);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sbus.done) dones++;
    end
    check("busy_start/extra_done", 64'(dones), 64'd0);
    $display("op busy_start sum=%08h cycle=%0d extra_dones=%0d", sbus.sum, cyc, dones);

    // Reset asserted at cycle 3 of an operation.
    start_op(0, 32'h40000000, 32'h40000000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort/sum", 64'(sbus.sum), 64'd0);
    check("abort/busy", 64'(sbus.busy), 64'd0);
    check("abort/done", 64'(sbus.done), 64'd0);
    check("abort/flags", 64'(sbus.flags), 64'd0);
    @(negedge clk); reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (sbus.done) dones++;
    end
    check("abort/no_done", 64'(dones), 64'd0);
    $display("op abort sum=%08h busy=%0d dones=%0d", sbus.sum, sbus.busy, dones);

    // Start issued in the done cycle of the previous operation.
    run("chain_a", 0, 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 6);
    run("chain_b", 0, 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
